// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter, program RAM read port, return FIFO and decoder handshake.
// Define IFETCH_PREFETCH_EN for a 2-entry prefetch FIFO; otherwise one entry and no prefetch.

module instr_fetch #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 64,
  parameter int PROG_LEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              halt_req,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              pram_ena,
  output logic              pram_rea,
  output logic [ADDR_W-1:0] pram_addr,
  input  logic [DATA_W-1:0] pram_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              err_nxt;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;
  entry_t            fifo [DEPTH];
  entry_t            fifo_nxt [DEPTH];
  logic [1:0]        count, count_nxt;
  logic              issue, flush, head_pop, pop, push, credit;
  entry_t            push_entry;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a <= LAST_ADDR;
  endfunction

  // A halt or jump empties the FIFO and drops any read still in flight.
  assign flush      = (state != IDLE) && (halt_req || jump_valid);
  assign head_pop   = instr_valid && instr_ready;
  assign pop        = head_pop && !flush;
  assign push       = inflight && !flush;
  assign credit     = ((int'(count) + int'(inflight)) < DEPTH) || head_pop;
  assign push_entry = '{addr: inflight_addr, data: pram_data};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    err_nxt   = addr_err;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          err_nxt = !in_range(start_addr);
          if (in_range(start_addr)) begin
            pc_nxt    = start_addr;
            state_nxt = RUN;
          end
        end
      end
      RUN, DRAIN: begin
        if (halt_req) begin
          state_nxt = IDLE;
        end else if (jump_valid) begin
          if (in_range(jump_addr)) begin
            pc_nxt    = jump_addr;
            state_nxt = RUN;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (state == RUN) begin
          if (credit) begin
            issue  = 1'b1;
            pc_nxt = pc + ADDR_W'(1);
            if (pc == LAST_ADDR) state_nxt = DRAIN;
          end
        end else if (count == 2'd0 && !inflight) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Head always lives in slot 0; with at most two slots a pop is a single move.
  always_comb begin
    fifo_nxt  = fifo;
    count_nxt = count;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      if (pop) begin
        fifo_nxt[0] = fifo[DEPTH-1];
        count_nxt   = count_nxt - 2'd1;
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(count_nxt)) fifo_nxt[i] = push_entry;
        end
        count_nxt = count_nxt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pc            <= '0;
      addr_err      <= 1'b0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      count         <= 2'd0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      addr_err <= err_nxt;
      inflight <= issue;
      if (issue) inflight_addr <= pc;
      count    <= count_nxt;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= fifo_nxt[i];
    end
  end

  assign pram_ena    = issue;
  assign pram_rea    = issue;
  assign pram_addr   = issue ? pc : '0;
  assign instr_valid = (count != 2'd0);
  assign instr_data  = fifo[0].data;
  assign instr_addr  = fifo[0].addr;
  assign busy        = (state != IDLE);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the control core. It drives the read port of the 64-bit program RAM: the RAM is read when `ena & rea` are high and returns data one cycle later. The unit maintains the program counter, handles jump and halt requests, and buffers returned words. It presents instructions to the decoder over a valid/ready handshake.

## Interface
- `ADDR_W`, 11, program RAM address width.
- `DATA_W`, 64, instruction width.
- `PROG_LEN`, 32, number of valid program words; legal addresses are 0..PROG_LEN-1.

- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin fetching at `start_addr`; honoured only in IDLE.
- `start_addr`  in  ADDR_W  first fetch address.
- `halt_req`  in  1  abort fetching and return to IDLE.
- `jump_valid`  in  1  redirect the PC.
- `jump_addr`  in  ADDR_W  redirect target.
- `pram_ena`  out  1  RAM enable.
- `pram_rea`  out  1  RAM read enable; always equal to `pram_ena`.
- `pram_addr`  out  ADDR_W  RAM read address.
- `pram_data`  in  DATA_W  RAM read data; valid the cycle after an issue.
- `instr_valid`  out  1  `instr_data` is valid.
- `instr_ready`  in  1  decoder accepts the instruction.
- `instr_data`  out  DATA_W  instruction word.
- `instr_addr`  out  ADDR_W  address of `instr_data`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last word is drained.
- `addr_err`  out  1  sticky flag: a jump target was ≥ PROG_LEN.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** on `start`. Load `pc = start_addr` and clear `addr_err`.
  - If `start_addr ≥ PROG_LEN`, set `addr_err` and stay in IDLE.
- **Issue:** in RUN, a read is issued when the credit condition holds (see Configuration). On issue:
  - drive `pram_ena = pram_rea = 1` and `pram_addr = pc`;
  - `pc` increments by 1.
  - An issue of address PROG_LEN-1 moves the state to DRAIN; no further issues are made.
- **Read return:** the word returned on `pram_data` the cycle after an issue is written to the FIFO together with its address. This always fits, by credit.
- **Output:** the FIFO head drives `instr_valid`, `instr_data`, `instr_addr`. The head pops when `instr_valid & instr_ready`.
- **DRAIN → IDLE:** when the FIFO is empty and no read is in flight. `done` pulses for one cycle.
- **Jump** (`jump_valid` in RUN or DRAIN):
  - flush the FIFO;
  - mark any in-flight read as discard, so its return is dropped;
  - set `pc = jump_addr` and go to RUN;
  - make no issue in that cycle.
  - If `jump_addr ≥ PROG_LEN`: set `addr_err`, flush, go to IDLE.
- **Halt** (`halt_req` in RUN or DRAIN): flush, discard any in-flight read, go to IDLE. No `done` pulse.
- **Priority:** `halt_req` > `jump_valid` > issue. A pop in the same cycle as a flush has no effect beyond the flush.
- **Ignored inputs:** `jump_valid` and `halt_req` are ignored in IDLE; `start` is ignored outside IDLE.

## Timing
- **Reset values:** all outputs 0; state IDLE; `pc` 0; FIFO empty; in-flight flag clear.
- **Reset assertion:** takes effect asynchronously mid-operation. Any returning RAM data is ignored after reset.
- **Start latency:** `start` in cycle 0 → issue in cycle 1 → `pram_data` in cycle 2 → `instr_valid` in cycle 3.
- **Output stability:** `instr_data` and `instr_addr` hold stable while `instr_valid & !instr_ready`.
- **Jump latency:** `jump_valid` in cycle N → `instr_valid` is low in cycle N+1 → first issue of `jump_addr` in cycle N+1 → `instr_valid` for that word in cycle N+3.
- **PC width:** `pc` is ADDR_W bits. It never wraps, because fetching stops at PROG_LEN-1.

## Configuration
- Macro: `IFETCH_PREFETCH_EN`.
- **Defined:**
  - FIFO depth is 2.
  - An issue is allowed when (FIFO count + in-flight) < 2, or when a pop occurs in the same cycle.
  - With `instr_ready` held high, sustained throughput is 1 instruction per cycle.
- **Undefined:**
  - FIFO depth is 1.
  - An issue is allowed only when the FIFO is empty and nothing is in flight, or when the single entry pops in the same cycle.
  - Sustained throughput is 1 instruction per 2 cycles.
- Ordering, jump, halt and error behaviour are identical in both modes.

## Test plan
- **Straight run:** PROG_LEN=4, `start_addr=0`, `instr_ready=1`. Required:
  - `instr_addr` = 0,1,2,3 in cycles 3–6 with the prefetch macro defined;
  - with the macro undefined, the same addresses appear in cycles 3, 5, 7, 9;
  - `done` pulses once, then `busy=0`.
- **Backpressure:** `instr_ready=0` for cycles 3–10, then 1. Required:
  - word 0 is held stable throughout;
  - at most 2 (prefetch) or 1 (no prefetch) reads are issued before the stall;
  - no word is lost or duplicated.
- **Jump with data in flight:** jump to address 20 in cycle 4. Required:
  - words issued before the jump are never presented, except those accepted before cycle 4;
  - `instr_addr=20` appears in cycle 7.
- **Bad jump:** `jump_addr=40` with PROG_LEN=32. Required:
  - `addr_err=1`, state IDLE, no `done`;
  - a following `start` clears `addr_err`.
- **Halt mid-run:** `halt_req` in cycle 5. Required:
  - `instr_valid=0` from cycle 6;
  - no further `pram_ena`;
  - `busy=0`.
- **Async reset:** `reset_n` low mid-DRAIN. Required:
  - all outputs are 0 immediately;
  - after release, `start` behaves as in the straight-run case.
